bridge_wait: RTL

- Parametrised successor to the fixed two-timer bridge: decodes CPU loads/stores onto N_DEV equal-stride device windows plus one bridge-local control window.
- Adds a req/ack handshake with device wait states, a timeout that raises a bus error, and per-source interrupt pending/mask/edge logic ahead of hwirq.
- Sits between the CPU memory stage and the peripheral slaves (timers and others).

---
 rtl/bridge_pkg.sv | 17 +
 rtl/bridge_irq_ctrl.sv | 49 ++++
 rtl/bridge_wait.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// bridge_pkg: shared state encoding, control register indices and hwirq placement
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Control registers are addressed by word index within the 16-byte window.
    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_RAW  = 2'd2;

    localparam int HWIRQ_BASE = 2;

endpackage

// File: rtl/bridge_irq_ctrl.sv
// bridge_irq_ctrl: interrupt pending/mask/edge logic and control register read mux
module bridge_irq_ctrl
    import bridge_pkg::*;
#(
    parameter int               N_DEV    = 2,
    parameter logic [N_DEV-1:0] IRQ_EDGE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [1:0]            word,
    input  logic [N_DEV:0]        wdata,
    input  logic [N_DEV-1:0]      dev_irq,
    input  logic                  test_interrupt,
    output logic [31:0]           rdata,
    output logic [7:HWIRQ_BASE]   hwirq
);

    logic [N_DEV:0]   pend_q, pend_d, mask_q, mask_d, raw, w1c;
    logic [N_DEV-1:0] prev_q;

    always_comb begin
        raw    = {test_interrupt, dev_irq};
        w1c    = (wr_en && word == REG_PEND) ? wdata : '0;
        mask_d = (wr_en && word == REG_MASK) ? wdata : mask_q;
        // Edge sources: a fresh rising edge outranks a simultaneous clear.
        for (int i = 0; i < N_DEV; i++)
            pend_d[i] = IRQ_EDGE[i] ? ((dev_irq[i] & ~prev_q[i]) | (pend_q[i] & ~w1c[i])) : dev_irq[i];
        pend_d[N_DEV] = test_interrupt;
        rdata = (word == REG_PEND) ? 32'(pend_q) :
                (word == REG_MASK) ? 32'(mask_q) :
                (word == REG_RAW)  ? 32'(raw)    : 32'd0;
        hwirq = '0;
        hwirq[HWIRQ_BASE +: N_DEV+1] = pend_q & mask_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            mask_q <= '1;
            prev_q <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            prev_q <= dev_irq;
        end
    end

endmodule

// File: rtl/bridge_wait.sv
// bridge_wait: CPU-to-peripheral bridge with device wait states, timeout bus error
// and a local interrupt control window.
module bridge_wait
    import bridge_pkg::*;
#(
    parameter int               N_DEV      = 2,
    parameter logic [31:0]      DEV_BASE0  = 32'h0000_7F00,
    parameter logic [31:0]      DEV_STRIDE = 32'h10,
    parameter logic [31:0]      CTRL_BASE  = 32'h0000_7F80,
    parameter int               TIMEOUT    = 16,
    parameter logic [N_DEV-1:0] IRQ_EDGE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [31:0]           addr,
    input  logic                  write_enable,
    input  logic [3:0]            byte_en,
    input  logic [31:0]           write_data,
    output logic                  ready,
    output logic [31:0]           read_result,
    output logic                  bus_err,
    output logic [N_DEV-1:0]      dev_sel,
    output logic [31:0]           dev_addr,
    output logic                  dev_we,
    output logic [3:0]            dev_be,
    output logic [31:0]           dev_wdata,
    input  logic [32*N_DEV-1:0]   dev_rdata,
    input  logic [N_DEV-1:0]      dev_ack,
    input  logic [N_DEV-1:0]      dev_irq,
    input  logic                  test_interrupt,
    output logic [5:0]            hwirq
);

    localparam int          SH       = $clog2(DEV_STRIDE);
    localparam int          CW       = $clog2(TIMEOUT);
    localparam logic [31:0] DEV_SPAN = 32'(N_DEV) * DEV_STRIDE;

    state_t           state_q, state_d;
    logic [N_DEV-1:0] dev_sel_q, dev_sel_d;
    logic [31:0]      dev_addr_q, dev_addr_d, dev_wdata_q, dev_wdata_d;
    logic [31:0]      read_result_q, read_result_d;
    logic [3:0]       dev_be_q, dev_be_d;
    logic             dev_we_q, dev_we_d, bus_err_q, bus_err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      off, ctrl_off, sel_rdata, ctrl_rdata;
    logic             dev_hit, ctrl_hit, ack, ctrl_we;

    bridge_irq_ctrl #(.N_DEV(N_DEV), .IRQ_EDGE(IRQ_EDGE)) u_irq (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (ctrl_we),
        .word           (addr[3:2]),
        .wdata          (write_data[N_DEV:0]),
        .dev_irq        (dev_irq),
        .test_interrupt (test_interrupt),
        .rdata          (ctrl_rdata),
        .hwirq          (hwirq)
    );

    always_comb begin
        off       = addr - DEV_BASE0;
        ctrl_off  = addr - CTRL_BASE;
        dev_hit   = (addr >= DEV_BASE0) && (off < DEV_SPAN);
        ctrl_hit  = (addr >= CTRL_BASE) && (ctrl_off < 32'd16);
        ack       = |(dev_ack & dev_sel_q);
        sel_rdata = '0;
        for (int i = 0; i < N_DEV; i++)
            if (dev_sel_q[i]) sel_rdata = sel_rdata | dev_rdata[32*i +: 32];
        state_d       = state_q;
        dev_sel_d     = dev_sel_q;
        dev_addr_d    = dev_addr_q;
        dev_we_d      = dev_we_q;
        dev_be_d      = dev_be_q;
        dev_wdata_d   = dev_wdata_q;
        read_result_d = read_result_q;
        bus_err_d     = bus_err_q;
        cnt_d         = cnt_q;
        ctrl_we       = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                if (dev_hit) begin
                    state_d     = ACCESS;
                    dev_sel_d   = N_DEV'(1) << (off >> SH);
                    dev_addr_d  = off & (DEV_STRIDE - 32'd1);
                    dev_we_d    = write_enable;
                    dev_be_d    = byte_en;
                    dev_wdata_d = write_data;
                    cnt_d       = '0;
                end else begin
                    state_d       = RESP;
                    ctrl_we       = ctrl_hit && write_enable;
                    read_result_d = ctrl_hit ? ctrl_rdata : 32'd0;
                    bus_err_d     = !ctrl_hit;
                end
            end
            ACCESS: begin
                if (ack || cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    dev_sel_d     = '0;
                    dev_we_d      = 1'b0;
                    read_result_d = ack ? sel_rdata : 32'd0;
                    bus_err_d     = !ack;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            dev_sel_q     <= '0;
            dev_addr_q    <= '0;
            dev_we_q      <= 1'b0;
            dev_be_q      <= '0;
            dev_wdata_q   <= '0;
            read_result_q <= '0;
            bus_err_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            dev_sel_q     <= dev_sel_d;
            dev_addr_q    <= dev_addr_d;
            dev_we_q      <= dev_we_d;
            dev_be_q      <= dev_be_d;
            dev_wdata_q   <= dev_wdata_d;
            read_result_q <= read_result_d;
            bus_err_q     <= bus_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign ready       = (state_q == RESP);
    assign read_result = read_result_q;
    assign bus_err     = bus_err_q && ready;
    assign dev_sel     = dev_sel_q;
    assign dev_addr    = dev_addr_q;
    assign dev_we      = dev_we_q;
    assign dev_be      = dev_be_q;
    assign dev_wdata   = dev_wdata_q;

endmodule
